// File: rtl/regfile_pkg.sv
// Shared types, constants and the one-hot write decode helper for the
// multi-port register file.
package regfile_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int MAX_DEPTH  = 1024;
  localparam int ZERO_IDX   = 0;

  typedef logic [DW_DEFAULT-1:0] word_t;

  // Returns a MAX_DEPTH-wide one-hot vector; callers truncate to their depth.
  // Selects at or beyond depth produce no enable at all.
  function automatic logic [MAX_DEPTH-1:0] onehot_dec(input logic [31:0] sel,
                                                      input logic        en,
                                                      input int unsigned depth);
    logic [MAX_DEPTH-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      res[i] = en && (sel == i) && (i < depth);
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_wen_decoder.sv
// Per-port write-enable decoder: one-hot register enable from a write select,
// suppressing out-of-range selects and, optionally, the hardwired zero register.
module wen_decoder
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             WEN,
  input  logic [AW-1:0]    wsel,
  output logic [DEPTH-1:0] en
);

  logic valid;

  assign valid = WEN && !((ZERO_REG != 0) && (wsel == AW'(ZERO_IDX)));
  assign en    = DEPTH'(onehot_dec(32'(wsel), valid, unsigned'(DEPTH)));

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with highest-port-wins write merging,
// optional zero register, optional write-to-read bypass and a conflict flag.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_WR   = 1,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_WR-1:0]            WEN,
  input  logic [NUM_WR-1:0][AW-1:0]    wsel,
  input  logic [NUM_WR-1:0][DW-1:0]    wdat,
  input  logic [NUM_RD-1:0][AW-1:0]    rsel,
  output logic [NUM_RD-1:0][DW-1:0]    rdat,
  output logic                         wconflict
);

  logic [NUM_WR-1:0][DEPTH-1:0] en;
  logic [DEPTH-1:0]             reg_we;
  logic [DW-1:0]                reg_wd [DEPTH];
  logic [DW-1:0]                mem    [DEPTH];
  logic                         conflict_next;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_dec
    wen_decoder #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_dec (
      .WEN  (WEN[p]),
      .wsel (wsel[p]),
      .en   (en[p])
    );
  end

  // Later ports overwrite earlier ones, so the highest-numbered port wins;
  // a second hit on an already-enabled register marks a conflict.
  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      reg_we[i] = 1'b0;
      reg_wd[i] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (en[p][i]) begin
          if (reg_we[i]) conflict_next = 1'b1;
          reg_we[i] = 1'b1;
          reg_wd[i] = wdat[p];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wconflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (reg_we[i]) mem[i] <= reg_wd[i];
      end
      wconflict <= conflict_next;
    end
  end

  // The zero-register override is applied last so it beats the bypass path.
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [DW-1:0] val;
    logic          in_range;

    assign in_range = 32'(rsel[r]) < 32'(DEPTH);

    always_comb begin
      val = '0;
      if (in_range) begin
        val = mem[rsel[r]];
        if ((BYPASS != 0) && reg_we[rsel[r]]) val = reg_wd[rsel[r]];
      end
      if ((ZERO_REG != 0) && (rsel[r] == AW'(ZERO_IDX))) val = '0;
    end

    assign rdat[r] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp across three configurations:
// A (2W/2R, no bypass), B (depth 24, bypass) and C (1W/1R, no zero register).
module tb_regfile_mp;

  logic CLK;
  logic nRST;

  logic [1:0]        a_wen;
  logic [1:0][4:0]   a_wsel;
  logic [1:0][31:0]  a_wdat;
  logic [1:0][4:0]   a_rsel;
  logic [1:0][31:0]  a_rdat;
  logic              a_wconf;

  logic [1:0]        b_wen;
  logic [1:0][4:0]   b_wsel;
  logic [1:0][31:0]  b_wdat;
  logic [1:0][4:0]   b_rsel;
  logic [1:0][31:0]  b_rdat;
  logic              b_wconf;

  logic [0:0]        c_wen;
  logic [0:0][4:0]   c_wsel;
  logic [0:0][31:0]  c_wdat;
  logic [0:0][4:0]   c_rsel;
  logic [0:0][31:0]  c_rdat;
  logic              c_wconf;

  int total;
  int bad;

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_WR(2), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_a (
    .CLK(CLK), .nRST(nRST), .WEN(a_wen), .wsel(a_wsel), .wdat(a_wdat),
    .rsel(a_rsel), .rdat(a_rdat), .wconflict(a_wconf)
  );

  regfile_mp #(.DW(32), .DEPTH(24), .NUM_WR(2), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_b (
    .CLK(CLK), .nRST(nRST), .WEN(b_wen), .wsel(b_wsel), .wdat(b_wdat),
    .rsel(b_rsel), .rdat(b_rdat), .wconflict(b_wconf)
  );

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_WR(1), .NUM_RD(1), .ZERO_REG(0), .BYPASS(0)) u_c (
    .CLK(CLK), .nRST(nRST), .WEN(c_wen), .wsel(c_wsel), .wdat(c_wdat),
    .rsel(c_rsel), .rdat(c_rdat), .wconflict(c_wconf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    total++;
    if (a_rdat[0] !== 32'h0 || a_wconf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_initial got=%h/%b exp=00000000/0", a_rdat[0], a_wconf);
    end
    @(negedge CLK);
    nRST = 1'b1;
    a_wen = 2'b01; a_wsel[0] = 5'd5; a_wdat[0] = 32'hDEADBEEF; a_rsel[0] = 5'd5;
    step();
    a_wen = 2'b00;
    #1;
    total++;
    if (a_rdat[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL reset_prewrite got=%h exp=deadbeef", a_rdat[0]);
    end
    a_wen = 2'b01; a_wsel[0] = 5'd6; a_wdat[0] = 32'h66666666; a_rsel[1] = 5'd6;
    #2 nRST = 1'b0;
    #1;
    total++;
    if (a_rdat[0] !== 32'h0 || a_wconf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_async got=%h/%b exp=00000000/0", a_rdat[0], a_wconf);
    end
    step();
    a_wen = 2'b00;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    total++;
    if (a_rdat[1] !== 32'h0 || a_rdat[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_wins got=%h/%h exp=00000000/00000000", a_rdat[1], a_rdat[0]);
    end
  endtask

  task automatic test_basic();
    c_wen = 1'b1; c_wsel[0] = 5'd7; c_wdat[0] = 32'h11111111; c_rsel[0] = 5'd7;
    step();
    c_wdat[0] = 32'h12345678;
    #1;
    total++;
    if (c_rdat[0] !== 32'h11111111) begin
      bad++;
      $display("[TB] FAIL basic_samecycle got=%h exp=11111111", c_rdat[0]);
    end
    step();
    c_wen = 1'b0;
    #1;
    total++;
    if (c_rdat[0] !== 32'h12345678) begin
      bad++;
      $display("[TB] FAIL basic_after got=%h exp=12345678", c_rdat[0]);
    end
    c_wen = 1'b1; c_wsel[0] = 5'd0; c_wdat[0] = 32'hA5A5A5A5; c_rsel[0] = 5'd0;
    step();
    c_wen = 1'b0;
    #1;
    total++;
    if (c_rdat[0] !== 32'hA5A5A5A5) begin
      bad++;
      $display("[TB] FAIL basic_reg0_writable got=%h exp=a5a5a5a5", c_rdat[0]);
    end
  endtask

  task automatic test_zero_reg();
    a_wen = 2'b01; a_wsel[0] = 5'd0; a_wdat[0] = 32'hFFFFFFFF; a_rsel[0] = 5'd0;
    b_wen = 2'b01; b_wsel[0] = 5'd0; b_wdat[0] = 32'hFFFFFFFF; b_rsel[0] = 5'd0;
    #1;
    total++;
    if (a_rdat[0] !== 32'h0 || b_rdat[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL zero_samecycle got=%h/%h exp=00000000/00000000", a_rdat[0], b_rdat[0]);
    end
    step();
    a_wen = 2'b00; b_wen = 2'b00;
    #1;
    total++;
    if (a_rdat[0] !== 32'h0 || b_rdat[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL zero_after got=%h/%h exp=00000000/00000000", a_rdat[0], b_rdat[0]);
    end
  endtask

  task automatic test_conflict();
    a_wen = 2'b11; a_wsel[0] = 5'd3; a_wsel[1] = 5'd3;
    a_wdat[0] = 32'h0000AAAA; a_wdat[1] = 32'h00005555; a_rsel[0] = 5'd3;
    #1;
    total++;
    if (a_rdat[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL conflict_oldvalue got=%h exp=00000000", a_rdat[0]);
    end
    step();
    a_wen = 2'b00;
    #1;
    total++;
    if (a_rdat[0] !== 32'h00005555 || a_wconf !== 1'b1) begin
      bad++;
      $display("[TB] FAIL conflict_winner got=%h/%b exp=00005555/1", a_rdat[0], a_wconf);
    end
    step();
    total++;
    if (a_wconf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL conflict_oneshot got=%b exp=0", a_wconf);
    end
    a_wen = 2'b11; a_wsel[0] = 5'd1; a_wsel[1] = 5'd2;
    a_wdat[0] = 32'h00000111; a_wdat[1] = 32'h00000222;
    step();
    a_wen = 2'b00; a_rsel[0] = 5'd1; a_rsel[1] = 5'd2;
    #1;
    total++;
    if (a_rdat[0] !== 32'h00000111 || a_rdat[1] !== 32'h00000222 || a_wconf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL conflict_distinct got=%h/%h/%b exp=00000111/00000222/0",
               a_rdat[0], a_rdat[1], a_wconf);
    end
    a_wen = 2'b11; a_wsel[0] = 5'd0; a_wsel[1] = 5'd0;
    step();
    a_wen = 2'b00;
    #1;
    total++;
    if (a_wconf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL conflict_reg0 got=%b exp=0", a_wconf);
    end
  endtask

  task automatic test_bypass();
    b_wen = 2'b01; b_wsel[0] = 5'd10; b_wdat[0] = 32'h00001010;
    step();
    b_wsel[0] = 5'd9; b_wdat[0] = 32'h0000CAFE; b_rsel[0] = 5'd9; b_rsel[1] = 5'd10;
    #1;
    total++;
    if (b_rdat[0] !== 32'h0000CAFE || b_rdat[1] !== 32'h00001010) begin
      bad++;
      $display("[TB] FAIL bypass_forward got=%h/%h exp=0000cafe/00001010", b_rdat[0], b_rdat[1]);
    end
    b_wen = 2'b11; b_wsel[1] = 5'd9; b_wdat[0] = 32'h00000001; b_wdat[1] = 32'h00000002;
    #1;
    total++;
    if (b_rdat[0] !== 32'h00000002) begin
      bad++;
      $display("[TB] FAIL bypass_priority got=%h exp=00000002", b_rdat[0]);
    end
    step();
    b_wen = 2'b00;
    #1;
    total++;
    if (b_rdat[0] !== 32'h00000002 || b_rdat[1] !== 32'h00001010 || b_wconf !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bypass_stored got=%h/%h/%b exp=00000002/00001010/1",
               b_rdat[0], b_rdat[1], b_wconf);
    end
  endtask

  task automatic test_depth();
    b_wen = 2'b01; b_wsel[0] = 5'd28; b_wdat[0] = 32'hBAD0BAD0;
    b_rsel[0] = 5'd28; b_rsel[1] = 5'd12;
    #1;
    total++;
    if (b_rdat[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL depth_oor_bypass got=%h exp=00000000", b_rdat[0]);
    end
    step();
    b_wen = 2'b00;
    #1;
    total++;
    if (b_rdat[0] !== 32'h0 || b_rdat[1] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL depth_oor_dropped got=%h/%h exp=00000000/00000000", b_rdat[0], b_rdat[1]);
    end
    b_rsel[1] = 5'd4;
    #1;
    total++;
    if (b_rdat[1] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL depth_alias4 got=%h exp=00000000", b_rdat[1]);
    end
    b_wen = 2'b01; b_wsel[0] = 5'd23; b_wdat[0] = 32'h00002323;
    step();
    b_wen = 2'b00; b_rsel[0] = 5'd23;
    #1;
    total++;
    if (b_rdat[0] !== 32'h00002323) begin
      bad++;
      $display("[TB] FAIL depth_last got=%h exp=00002323", b_rdat[0]);
    end
    a_wen = 2'b01; a_wsel[0] = 5'd31; a_wdat[0] = 32'h31313131;
    step();
    a_wen = 2'b00; a_rsel[0] = 5'd31;
    #1;
    total++;
    if (a_rdat[0] !== 32'h31313131) begin
      bad++;
      $display("[TB] FAIL depth_reg31 got=%h exp=31313131", a_rdat[0]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    a_wen = '0; a_wsel = '0; a_wdat = '0; a_rsel = '0;
    b_wen = '0; b_wsel = '0; b_wdat = '0; b_rsel = '0;
    c_wen = '0; c_wsel = '0; c_wdat = '0; c_rsel = '0;
    test_reset();
    test_basic();
    test_zero_reg();
    test_conflict();
    test_bypass();
    test_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
